cpu_clk_ctrl: RTL and testbench

CPU_CLK_CTRL -- requirements
Module: cpu_clk_ctrl

---
 rtl/cpu_clk_ctrl.sv | 136 +++++++++++++
 tb/tb_cpu_clk_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cpu_clk_ctrl
// Brief    : Run / halt / single-step CPU clock-enable generator with a
//            selectable fast or slow pulse rate. Breakpoint support is added
//            when the macro CPU_CLK_CTRL_BREAKPOINT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_clk_ctrl #(
  parameter int unsigned FAST_DIV = 16,
  parameter int unsigned SLOW_DIV = 67108864
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_sw,
  input  logic        step_btn,
  input  logic        rate_sel,
`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
  input  logic [31:0] pc,
  input  logic [31:0] bp_addr,
  input  logic        bp_valid,
  output logic        bp_hit,
`endif
  output logic        cpu_en,
  output logic        halted,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [1:0] {
    HALT      = 2'd0,
    RUN       = 2'd1,
    STEP      = 2'd2,
    STEP_WAIT = 2'd3
  } state_t;

  localparam logic [31:0] FAST_LAST = 32'(FAST_DIV - 1);
  localparam logic [31:0] SLOW_LAST = 32'(SLOW_DIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic        step_q;
  logic        rate_q;
  logic [31:0] div_cnt;
  logic [31:0] div_nxt;
  logic [31:0] div_last;
  logic        step_rise;
  logic        rate_chg;
  logic        en_nxt;
  logic        bp_match;
  logic        bp_block;

  assign step_rise = step_btn & ~step_q;
  assign rate_chg  = rate_sel ^ rate_q;
  assign div_last  = rate_sel ? SLOW_LAST : FAST_LAST;
  assign halted    = (state != RUN);

`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
  assign bp_match = (state == RUN) && bp_valid && (pc == bp_addr);
  assign bp_block = bp_hit;

  // Sticky until the operator drops run_sw; a match while run_sw=0 is moot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_hit <= 1'b0;
    end else if (!run_sw) begin
      bp_hit <= 1'b0;
    end else if (bp_match) begin
      bp_hit <= 1'b1;
    end
  end
`else
  assign bp_match = 1'b0;
  assign bp_block = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    div_nxt   = '0;
    case (state)
      HALT: begin
        if (run_sw && !bp_block) begin
          state_nxt = RUN;
        end else if (step_rise) begin
          state_nxt = STEP;
        end
      end
      RUN: begin
        if (!run_sw || bp_match) begin
          state_nxt = HALT;
        end else if (rate_chg || (div_cnt == div_last)) begin
          div_nxt = '0;
        end else begin
          div_nxt = div_cnt + 32'd1;
        end
      end
      STEP: begin
        state_nxt = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (!step_btn) begin
          state_nxt = HALT;
        end
      end
      default: begin
        state_nxt = HALT;
      end
    endcase

    // cpu_en is registered: it is high in the cycle div_cnt sits at N-1, or
    // in the cycle right after the one-cycle STEP state.
    en_nxt = (state == STEP) ||
             ((state == RUN) && (state_nxt == RUN) && !rate_chg && (div_nxt == div_last));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HALT;
      div_cnt   <= '0;
      step_q    <= 1'b0;
      rate_q    <= 1'b0;
      cpu_en    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      step_q  <= step_btn;
      rate_q  <= rate_sel;
      cpu_en  <= en_nxt;
      if (cpu_en) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_clk_ctrl
// Brief    : Directed self-checking bench for cpu_clk_ctrl (FAST_DIV=16,
//            SLOW_DIV=40). Breakpoint cases run when CPU_CLK_CTRL_BREAKPOINT_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_clk_ctrl;

  logic        clk;
  logic        rst;
  logic        run_sw;
  logic        step_btn;
  logic        rate_sel;
  logic        cpu_en;
  logic        halted;
  logic [31:0] cycle_cnt;
`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
  logic [31:0] pc;
  logic [31:0] bp_addr;
  logic        bp_valid;
  logic        bp_hit;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int first;
  int cnt;
  int gaps;
  int run_cyc;

  cpu_clk_ctrl #(
    .FAST_DIV(16),
    .SLOW_DIV(40)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run_sw   (run_sw),
    .step_btn (step_btn),
    .rate_sel (rate_sel),
`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
    .pc       (pc),
    .bp_addr  (bp_addr),
    .bp_valid (bp_valid),
    .bp_hit   (bp_hit),
`endif
    .cpu_en   (cpu_en),
    .halted   (halted),
    .cycle_cnt(cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Observe n cycles: first pulse index (1-based), pulse count, spacing errors
  // against 'period' (0 = don't care), and cycles spent with halted low.
  task automatic watch(input int n, input int period, output int f, output int c,
                       output int g, output int r);
    int last;
    f = 0; c = 0; g = 0; r = 0; last = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (!halted) r++;
      if (cpu_en) begin
        if (c == 0) f = i;
        else if (period != 0 && (i - last) != period) g++;
        last = i;
        c++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; run_sw = 1'b0; step_btn = 1'b0; rate_sel = 1'b0;
`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
    pc = 32'h0; bp_addr = 32'h0; bp_valid = 1'b0;
`endif
    #2;
    check("rst_cpu_en", 32'(cpu_en), 32'd0);
    check("rst_halted", 32'(halted), 32'd1);
    check("rst_cycle_cnt", cycle_cnt, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Free run at the fast rate
    run_sw = 1'b1;
    watch(160, 16, first, cnt, gaps, run_cyc);
    check("run_first_pulse", 32'(first), 32'd16);
    check("run_pulse_count", 32'(cnt), 32'd10);
    check("run_spacing_err", 32'(gaps), 32'd0);
    check("run_halted_low", 32'(run_cyc), 32'd160);
    tick();
    check("run_cycle_cnt_10", cycle_cnt, 32'd10);

    // Halt with div_cnt at 10, then re-run
    watch(10, 0, first, cnt, gaps, run_cyc);
    check("pre_halt_no_pulse", 32'(cnt), 32'd0);
    run_sw = 1'b0;
    tick();
    check("halt_cpu_en", 32'(cpu_en), 32'd0);
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_cycle_cnt", cycle_cnt, 32'd10);
    run_sw = 1'b1;
    watch(16, 0, first, cnt, gaps, run_cyc);
    check("rerun_first_pulse", 32'(first), 32'd16);
    check("rerun_pulse_count", 32'(cnt), 32'd1);

    // Rate switch fast->slow mid-count
    watch(6, 0, first, cnt, gaps, run_cyc);
    check("pre_rate_no_pulse", 32'(cnt), 32'd0);
    rate_sel = 1'b1;
    watch(40, 0, first, cnt, gaps, run_cyc);
    check("slow_first_pulse", 32'(first), 32'd40);
    check("slow_pulse_count", 32'(cnt), 32'd1);
    check("slow_cycle_cnt", cycle_cnt, 32'd11);
    run_sw = 1'b0;
    rate_sel = 1'b0;
    tick();
    check("halt2_halted", 32'(halted), 32'd1);
    check("halt2_cycle_cnt", cycle_cnt, 32'd12);

    // Held step button gives a single pulse
    step_btn = 1'b1;
    watch(50, 0, first, cnt, gaps, run_cyc);
    check("step_pulse_count", 32'(cnt), 32'd1);
    check("step_pulse_time", 32'(first), 32'd2);
    check("step_halted_low", 32'(run_cyc), 32'd0);
    step_btn = 1'b0;
    tick();
    tick();
    check("step_cycle_cnt", cycle_cnt, 32'd13);

    // Counter wrap on a single step
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.cycle_cnt;
    tick();
    check("wrap_preload", cycle_cnt, 32'hFFFF_FFFF);
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    tick();
    check("wrap_step_pulse", 32'(cpu_en), 32'd1);
    tick();
    check("wrap_cycle_cnt", cycle_cnt, 32'd0);
    check("wrap_pulse_end", 32'(cpu_en), 32'd0);

    // Asynchronous reset in the middle of a pulse
    run_sw = 1'b1;
    watch(32, 16, first, cnt, gaps, run_cyc);
    check("prerst_pulse_count", 32'(cnt), 32'd2);
    check("prerst_cpu_en", 32'(cpu_en), 32'd1);
    #2;
    rst = 1'b1;
    run_sw = 1'b0;
    step_btn = 1'b1;
    #1;
    check("arst_cpu_en", 32'(cpu_en), 32'd0);
    check("arst_halted", 32'(halted), 32'd1);
    check("arst_cycle_cnt", cycle_cnt, 32'd0);
    repeat (3) tick();
    rst = 1'b0;

    // Button held through reset release still yields one step
    watch(6, 0, first, cnt, gaps, run_cyc);
    check("rst_step_count", 32'(cnt), 32'd1);
    check("rst_step_time", 32'(first), 32'd2);
    step_btn = 1'b0;
    tick();
    tick();

`ifdef CPU_CLK_CTRL_BREAKPOINT_EN
    bp_addr = 32'h40; bp_valid = 1'b1; pc = 32'h0; run_sw = 1'b1;
    repeat (5) tick();
    pc = 32'h40;
    tick();
    check("bp_hit_set", 32'(bp_hit), 32'd1);
    check("bp_halted", 32'(halted), 32'd1);
    watch(5, 0, first, cnt, gaps, run_cyc);
    check("bp_no_resume", 32'(run_cyc), 32'd0);
    check("bp_no_pulse", 32'(cnt), 32'd0);
    run_sw = 1'b0;
    tick();
    check("bp_cleared", 32'(bp_hit), 32'd0);
    pc = 32'h44;
    run_sw = 1'b1;
    tick();
    check("bp_resume", 32'(halted), 32'd0);
    run_sw = 1'b0;
    tick();
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
